// File: rtl/game_palette_lut.sv
// game_palette_lut
// Banked colour palette lookup with a global brightness fader.
//
// A pixel index and a bank select are looked up in a two-stage pipeline.
// Stage 1 registers the raw {R,G,B} entry. Stage 2 registers that entry
// scaled by the current brightness level. out_valid follows in_valid
// exactly two cycles later, and there are no stalls.
//
// A small FSM walks the brightness level up or down by one step for every
// FADE_DIV frame_tick pulses. It pulses fade_done when it reaches the target.
//
// Ports
//   Clk, Reset_n         clock (rising edge), asynchronous active-low reset
//   in_valid, index,     lookup request: index into bank rd_bank
//   rd_bank
//   wr_en, wr_bank,      palette write of wr_data ({R,G,B}) to
//   wr_addr, wr_data     palette[wr_bank][wr_addr]
//   frame_tick           one-cycle pulse per video frame
//   fade_start, fade_dir fade request (dir 1 = fade in, 0 = fade out)
//   out_valid, red,      scaled colour result, two cycles after in_valid
//   green, blue
//   level                current brightness, 0..2^BRIGHT_W
//   fade_busy, fade_done fade in progress / one-cycle completion pulse
module game_palette_lut #(
    parameter int INDEX_W   = 4,
    parameter int COLOR_W   = 4,
    parameter int NUM_BANKS = 2,
    parameter int BRIGHT_W  = 4,
    parameter int FADE_DIV  = 2,
    // Entry e sits at bits [e*3*COLOR_W +: 3*COLOR_W]; entry 0 is rightmost.
    parameter logic [(2**INDEX_W)*3*COLOR_W-1:0] DEFAULT_PALETTE =
        192'h733_311_744_100_633_522_743_000_311_522_753_412_100_622_201_763,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   in_valid,
    input  logic [INDEX_W-1:0]     index,
    input  logic [BANK_W-1:0]      rd_bank,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [INDEX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0]   wr_data,
    input  logic                   frame_tick,
    input  logic                   fade_start,
    input  logic                   fade_dir,
    output logic                   out_valid,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic [BRIGHT_W:0]      level,
    output logic                   fade_busy,
    output logic                   fade_done
);

    localparam int ENTRIES = 2**INDEX_W;
    localparam int RGB_W   = 3*COLOR_W;
    localparam int LEVEL_W = BRIGHT_W+1;
    localparam int PROD_W  = COLOR_W+BRIGHT_W+1;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(1) << BRIGHT_W;
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FADE_DIV-1);

    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} state_t;

    // ------------------------------------------------------------------
    // Palette storage. The storage is a register array rather than block
    // RAM, because reset must reload every entry.
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] palette [NUM_BANKS][ENTRIES];

    wire wr_bank_ok = int'(wr_bank) < NUM_BANKS;
    wire rd_bank_ok = int'(rd_bank) < NUM_BANKS;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    palette[b][e] <= DEFAULT_PALETTE[e*RGB_W +: RGB_W];
                end
            end
        end else if (wr_en && wr_bank_ok) begin
            palette[wr_bank][wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline. Stage 1 samples the array before any same-edge
    // write lands, so a simultaneous write/read returns the old entry.
    // ------------------------------------------------------------------
    logic [RGB_W-1:0]   s1_rgb_reg;
    logic               s1_valid_reg;
    logic [RGB_W-1:0]   out_rgb_reg;
    logic               out_valid_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic [RGB_W-1:0]   scaled;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_rgb_reg   <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_rgb_reg <= rd_bank_ok ? palette[rd_bank][index] : '0;
            end
        end
    end

    // Per-channel scaling (c * L) >> BRIGHT_W. The product is computed at
    // full width. L <= 2^BRIGHT_W, so the result always fits in COLOR_W.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign scaled[gi*COLOR_W +: COLOR_W] =
                COLOR_W'((PROD_W'(s1_rgb_reg[gi*COLOR_W +: COLOR_W]) *
                          PROD_W'(level_reg)) >> BRIGHT_W);
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_rgb_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_rgb_reg <= scaled;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fade FSM
    // ------------------------------------------------------------------
    state_t             state_reg, state_next;
    logic [LEVEL_W-1:0] level_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               done_reg, done_next;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            level_reg <= LEVEL_MAX;
            div_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            div_reg   <= div_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        div_next   = div_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // frame_tick is ignored here. A tick that coincides with
                // fade_start is therefore never counted.
                if (fade_start) begin
                    if (fade_dir ? (level_reg == LEVEL_MAX) : (level_reg == '0)) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = fade_dir ? FADE_IN : FADE_OUT;
                        div_next   = '0;
                    end
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    if (div_reg == DIV_LAST) begin
                        div_next = '0;
                        if (level_reg != LEVEL_MAX) level_next = level_reg + LEVEL_ONE;
                        if (level_reg >= LEVEL_MAX - LEVEL_ONE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    if (div_reg == DIV_LAST) begin
                        div_next = '0;
                        if (level_reg != '0) level_next = level_reg - LEVEL_ONE;
                        if (level_reg <= LEVEL_ONE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        div_next = div_reg + DIV_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid = out_valid_reg;
    assign red       = out_rgb_reg[2*COLOR_W +: COLOR_W];
    assign green     = out_rgb_reg[1*COLOR_W +: COLOR_W];
    assign blue      = out_rgb_reg[0*COLOR_W +: COLOR_W];
    assign level     = level_reg;
    assign fade_busy = (state_reg != IDLE);
    assign fade_done = done_reg;

endmodule

// File: tb/tb_game_palette_lut.sv
// Directed testbench for game_palette_lut (default parameters).
module tb_game_palette_lut;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] index = '0;
    logic       rd_bank = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_bank = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic       frame_tick = 1'b0;
    logic       fade_start = 1'b0;
    logic       fade_dir = 1'b0;
    logic       out_valid;
    logic [3:0] red, green, blue;
    logic [4:0] level;
    logic       fade_busy, fade_done;

    int n_checks = 0;
    int n_fail   = 0;

    game_palette_lut dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .in_valid(in_valid), .index(index), .rd_bank(rd_bank),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
        .out_valid(out_valid), .red(red), .green(green), .blue(blue),
        .level(level), .fade_busy(fade_busy), .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge, and returns just after one. It
    // checks the 2-cycle latency, the result, the single-cycle valid and
    // that the output is held afterwards.
    task automatic do_lookup(input string name, input int bank, input int idx,
                             input int er, input int eg, input int eb);
        rd_bank = bank[0]; index = idx[3:0]; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        check({name, " valid@1"}, out_valid, 0);
        @(negedge Clk);
        check({name, " valid@2"}, out_valid, 1);
        check({name, " red"}, red, er);
        check({name, " green"}, green, eg);
        check({name, " blue"}, blue, eb);
        @(negedge Clk);
        check({name, " valid@3"}, out_valid, 0);
        check({name, " red hold"}, red, er);
        $display("lookup %s bank=%0d idx=%0d -> %0d,%0d,%0d", name, bank, idx, red, green, blue);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    typedef struct {
        int bank; int idx; int r; int g; int b;
    } vec_t;

    vec_t vecs [7];
    int   tp_idx [3];
    int   tp_exp [3][3];

    initial begin
        vecs[0] = '{0, 0, 7, 6, 3};
        vecs[1] = '{0, 8, 0, 0, 0};
        vecs[2] = '{0, 15, 7, 3, 3};
        vecs[3] = '{0, 5, 7, 5, 3};
        vecs[4] = '{1, 13, 7, 4, 4};
        vecs[5] = '{1, 1, 2, 0, 1};
        vecs[6] = '{0, 9, 7, 4, 3};
        tp_idx = '{0, 5, 15};
        tp_exp[0] = '{7, 6, 3};
        tp_exp[1] = '{7, 5, 3};
        tp_exp[2] = '{7, 3, 3};

        // ---------------- reset state ----------------
        repeat (2) @(negedge Clk);
        check("rst out_valid", out_valid, 0);
        check("rst red", red, 0);
        check("rst green", green, 0);
        check("rst blue", blue, 0);
        check("rst level", level, 16);
        check("rst busy", fade_busy, 0);
        check("rst done", fade_done, 0);
        $display("reset state checked: level=%0d busy=%0d", level, fade_busy);
        Reset_n = 1'b1;

        // ---------------- table of lookups at full brightness ----------------
        for (int i = 0; i < 7; i++) begin
            do_lookup($sformatf("tbl%0d", i), vecs[i].bank, vecs[i].idx,
                      vecs[i].r, vecs[i].g, vecs[i].b);
        end

        // ---------------- back-to-back throughput ----------------
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                rd_bank = 1'b0; index = tp_idx[k][3:0]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge Clk);
            if (k >= 1 && k <= 3) begin
                check($sformatf("b2b%0d valid", k-1), out_valid, 1);
                check($sformatf("b2b%0d red", k-1), red, tp_exp[k-1][0]);
                check($sformatf("b2b%0d green", k-1), green, tp_exp[k-1][1]);
                check($sformatf("b2b%0d blue", k-1), blue, tp_exp[k-1][2]);
                $display("b2b result %0d -> %0d,%0d,%0d", k-1, red, green, blue);
            end else begin
                check($sformatf("b2b slot%0d valid", k), out_valid, 0);
            end
        end

        // ---------------- write/read collision ----------------
        wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 4'd3; wr_data = 12'hFFF;
        in_valid = 1'b1; rd_bank = 1'b1; index = 4'd3;
        @(negedge Clk);
        wr_en = 1'b0;
        @(negedge Clk);
        in_valid = 1'b0;
        check("wrcoll old valid", out_valid, 1);
        check("wrcoll old red", red, 1);
        check("wrcoll old green", green, 0);
        check("wrcoll old blue", blue, 0);
        @(negedge Clk);
        check("wrcoll new valid", out_valid, 1);
        check("wrcoll new red", red, 15);
        check("wrcoll new green", green, 15);
        check("wrcoll new blue", blue, 15);
        $display("write collision: second read -> %0d,%0d,%0d", red, green, blue);
        @(negedge Clk);
        do_lookup("bank0 e3", 0, 3, 1, 0, 0);
        do_lookup("bank1 e3", 1, 3, 15, 15, 15);

        // ---------------- fade out 16 -> 0 ----------------
        fade_start = 1'b1; fade_dir = 1'b0;
        @(negedge Clk);
        fade_start = 1'b0;
        check("fo start busy", fade_busy, 1);
        check("fo start level", level, 16);
        for (int t = 1; t <= 32; t++) begin
            tick();
            check($sformatf("fo tick%0d level", t), level, 16 - t/2);
            check($sformatf("fo tick%0d done", t), fade_done, (t == 32) ? 1 : 0);
            check($sformatf("fo tick%0d busy", t), fade_busy, (t == 32) ? 0 : 1);
            $display("fade-out tick %0d level=%0d busy=%0d done=%0d", t, level, fade_busy, fade_done);
            if (t == 16) do_lookup("level8", 0, 0, 3, 3, 1);
        end
        @(negedge Clk);
        check("fo done pulse end", fade_done, 0);
        do_lookup("level0", 0, 0, 0, 0, 0);

        // ---------------- fade_start already at target ----------------
        fade_start = 1'b1; fade_dir = 1'b0;
        @(negedge Clk);
        fade_start = 1'b0;
        check("at-target done", fade_done, 1);
        check("at-target busy", fade_busy, 0);
        check("at-target level", level, 0);
        @(negedge Clk);
        check("at-target done end", fade_done, 0);
        $display("at-target fade_start handled, level=%0d", level);

        // ---------------- coincident tick and ignored restart ----------------
        fade_start = 1'b1; fade_dir = 1'b1; frame_tick = 1'b1;
        @(negedge Clk);
        fade_start = 1'b0; frame_tick = 1'b0;
        check("fi start busy", fade_busy, 1);
        check("fi start level", level, 0);
        fade_start = 1'b1; fade_dir = 1'b0;
        @(negedge Clk);
        fade_start = 1'b0;
        check("fi restart busy", fade_busy, 1);
        check("fi restart level", level, 0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("fi tick%0d level", t), level, t/2);
            check($sformatf("fi tick%0d busy", t), fade_busy, 1);
            $display("fade-in tick %0d level=%0d", t, level);
        end

        // ---------------- reset mid-fade, mid-pipeline ----------------
        rd_bank = 1'b0; index = 4'd0; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        check("midrst level", level, 16);
        check("midrst busy", fade_busy, 0);
        check("midrst done", fade_done, 0);
        check("midrst out_valid", out_valid, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            check($sformatf("midrst c%0d out_valid", c), out_valid, 0);
            check($sformatf("midrst c%0d done", c), fade_done, 0);
        end
        $display("reset mid-fade: level=%0d busy=%0d", level, fade_busy);
        Reset_n = 1'b1;
        do_lookup("post-rst bank1 e3", 1, 3, 1, 0, 0);
        check("post-rst done", fade_done, 0);

        // ---------------- frame_tick ignored in IDLE ----------------
        tick();
        check("idle tick level", level, 16);
        check("idle tick busy", fade_busy, 0);
        check("idle tick done", fade_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/game_palette_lut.md
GAME_PALETTE_LUT -- requirements
Module: game_palette_lut

Interface
REQ-001 The block SHALL have parameter INDEX_W, default 4, meaning the palette index width (2^INDEX_W entries per bank).
REQ-002 The block SHALL have parameter COLOR_W, default 4, meaning the width of each of the red, green and blue channels.
REQ-003 The block SHALL have parameter NUM_BANKS, default 2, meaning the number of independent palettes (BANK_W = max(1, clog2(NUM_BANKS))).
REQ-004 The block SHALL have parameter BRIGHT_W, default 4, meaning the brightness resolution (LEVEL_MAX = 2^BRIGHT_W).
REQ-005 The block SHALL have parameter FADE_DIV, default 2, meaning the number of frame_tick pulses per brightness step (>=1).
REQ-006 The block SHALL have parameter DEFAULT_PALETTE, meaning the reset contents of every bank; default entries 0..15 = 763,201,622,100,412,753,522,311,000,743,522,633,100,744,311,733 (hex RGB).
REQ-007 The block SHALL have the following ports (name  direction  width  meaning):
- Clk  in  1  sole clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel lookup request
- index  in  INDEX_W  palette index
- rd_bank  in  BANK_W  bank used for this lookup
- wr_en  in  1  palette write strobe
- wr_bank  in  BANK_W  write bank
- wr_addr  in  INDEX_W  write entry
- wr_data  in  3*COLOR_W  {R,G,B}
- frame_tick  in  1  one-cycle per-frame pulse
- fade_start  in  1  one-cycle fade request
- fade_dir  in  1  0 = fade out to black, 1 = fade in to full
- out_valid  out  1  red/green/blue valid
- red, green, blue  out  COLOR_W each  scaled colour
- level  out  BRIGHT_W+1  current brightness, 0..LEVEL_MAX
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse at fade completion

Function
REQ-008 Lookup SHALL be a 2-stage pipeline: stage 1 registers palette[rd_bank][index]; stage 2 registers the scaled colour; out_valid SHALL follow in_valid with exactly 2 cycles latency, one result per cycle, no stalls.
REQ-009 Each channel SHALL be computed as out = (c * L) >> BRIGHT_W, using full-width products and no rounding, where L = level sampled in the stage-2 cycle; L = LEVEL_MAX SHALL return c unchanged, and L = 0 SHALL return 0.
REQ-010 When in_valid = 0, stage registers SHALL hold their values and out_valid SHALL be 0.
REQ-011 wr_en SHALL update palette[wr_bank][wr_addr] at the clock edge.
REQ-012 A lookup of the same entry in the same cycle as its write SHALL return the old data; the new data SHALL be returned from the next cycle on.
REQ-013 rd_bank or wr_bank >= NUM_BANKS SHALL read zero and ignore the write.
REQ-014 The fade FSM SHALL have states IDLE, FADE_IN and FADE_OUT; fade_busy = 1 in FADE_IN and FADE_OUT.
REQ-015 In IDLE, fade_start SHALL go to FADE_IN (fade_dir = 1) or FADE_OUT (fade_dir = 0) and clear the tick divider.
REQ-016 fade_start while busy SHALL be ignored.
REQ-017 In a fade state, the tick divider SHALL count frame_tick pulses; on the FADE_DIV-th pulse, level SHALL step by +1 (FADE_IN) or -1 (FADE_OUT) and the divider SHALL clear.
REQ-018 When level reaches LEVEL_MAX (FADE_IN) or 0 (FADE_OUT), the FSM SHALL return to IDLE and assert fade_done for exactly 1 cycle.
REQ-019 level SHALL saturate and never wrap.
REQ-020 fade_start with level already at the target SHALL give IDLE plus a fade_done pulse on the next cycle, with level unchanged.
REQ-021 frame_tick coinciding with an accepted fade_start SHALL NOT be counted.
REQ-022 frame_tick in IDLE SHALL be ignored.

Reset
REQ-023 Reset_n = 0 SHALL asynchronously set: out_valid = 0; red/green/blue = 0; level = LEVEL_MAX; fade_busy = 0; fade_done = 0; FSM = IDLE; divider = 0; pipeline valid bits = 0; every bank = DEFAULT_PALETTE.
REQ-024 Reset asserted mid-fade or mid-pipeline SHALL abandon all in-flight work, with no fade_done and no out_valid.
REQ-025 The first lookup SHALL be accepted on the first rising edge after Reset_n deasserts.

Verification
REQ-026 Reset, then index = 0, bank 0, in_valid for 1 cycle -> 2 cycles later out_valid = 1 with RGB = 7,6,3 for 1 cycle; index = 8 -> 0,0,0.
REQ-027 Write bank 1 addr 3 = FFF while reading bank 1 index 3 in the same cycle, then read again -> first result = 1,0,0 and second = F,F,F; bank 0 entry 3 still 1,0,0.
REQ-028 fade_start with fade_dir = 0 and FADE_DIV = 2, then 32 frame_ticks -> level steps 16->0 every 2nd tick, fade_done pulses once at the 32nd tick, fade_busy falls with it.
REQ-029 level = 8, lookup index 0 -> RGB = 3,3,1; level = 0 -> 0,0,0.
REQ-030 fade_start and frame_tick together, then fade_start again while busy -> the first tick is not counted and the second request has no effect.
REQ-031 Reset_n pulsed low mid-fade at level 5 -> level = 16, IDLE, no fade_done, palette restored to defaults.
